// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, reads the instruction memory and queues {pc, instr} toward decode.
// Latency: a fetched word is visible on id_valid one cycle after its PC is presented on imem_a.
// Backpressure: a full FIFO with no pop stalls the PC; redirects flush the FIFO regardless of id_ready.

module ifetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
// Generic FIFO with a registered head: rd_dat is the storage cell at the read pointer.
// Latency: one cycle from write to rd_vld.
// Backpressure: wr_rdy low when full; the caller may still write when a pop occurs in the same cycle.

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop;

    assign wr_rdy = (count != CW'(DEPTH));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld && rd_rdy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_vld, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 6,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [IMEM_AW-1:0] imem_a,
    input  logic [31:0]        imem_rd,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc,
    output logic               fetch_fault,
    output logic [31:0]        fault_pc
);

    typedef enum logic {RUN, FAULT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        pc_legal;
    logic        fifo_rdy;
    logic        pop;
    logic        push;

    assign imem_a   = pc[IMEM_AW+1:2];
    assign pc_legal = (pc[1:0] == 2'b00) && (pc[31:IMEM_AW+2] == '0);
    assign pop      = id_valid && id_ready;
    assign push     = (state == RUN) && !redirect_valid && pc_legal && (fifo_rdy || pop);

    ifetch_fifo #(.W(64), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect_valid),
        .wr_vld  (push),
        .wr_dat  ({pc, imem_rd}),
        .wr_rdy  (fifo_rdy),
        .rd_vld  (id_valid),
        .rd_rdy  (id_ready),
        .rd_dat  ({id_pc, id_instr})
    );

    // A bad redirect target re-enters RUN; the bad-PC check faults it on the next cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else if (redirect_valid) begin
            state       <= RUN;
            pc          <= redirect_pc;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!pc_legal) begin
                        state       <= FAULT;
                        fetch_fault <= 1'b1;
                        fault_pc    <= pc;
                    end else if (push) begin
                        pc <= pc + 32'd4;
                    end
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random traffic, checked against a queue-based PC/FIFO model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    assign imem_rd = mem[imem_a];

    ifetch_unit #(.RESET_PC(32'h0), .IMEM_AW(6), .DEPTH(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_a         (imem_a),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: fetch pointer, stopped flag, fault report and a queue of {pc, instr}.
    logic [31:0] m_pc;
    bit          m_stopped;
    bit          m_fault;
    logic [31:0] m_fpc;
    logic [63:0] q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit pop;
        bit legal;
        pop   = (q.size() != 0) && id_ready;
        legal = (m_pc % 4 == 0) && (m_pc < 32'd256);
        if (!reset_n) begin
            q.delete();
            m_pc = 32'h0; m_stopped = 0; m_fault = 0; m_fpc = 32'h0;
        end else if (redirect_valid) begin
            q.delete();
            m_pc = redirect_pc; m_stopped = 0; m_fault = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (!m_stopped) begin
                if (!legal) begin
                    m_stopped = 1; m_fault = 1; m_fpc = m_pc;
                end else if (q.size() < 2) begin
                    q.push_back({m_pc, mem[m_pc / 4]});
                    m_pc = m_pc + 4;
                end
            end
        end
    endtask

    task automatic compare();
        chk("id_valid", {31'b0, id_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("id_pc", id_pc, q[0][63:32]);
            chk("id_instr", id_instr, q[0][31:0]);
        end
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        chk("fault_pc", fault_pc, m_fpc);
        chk("imem_a", {26'b0, imem_a}, {26'b0, m_pc[7:2]});
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0093;
        mem[1] = 32'h0010_0113;
        m_pc = 0; m_stopped = 0; m_fault = 0; m_fpc = 0;
        reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;

        // Reset state and basic streaming
        step(); step();
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        reset_n = 1'b1;
        chk("c0_imem_a", {26'b0, imem_a}, 32'h0);
        step();
        chk("c1_instr", id_instr, 32'h0000_0093);
        step();
        chk("c2_pc", id_pc, 32'h4);
        chk("c2_instr", id_instr, 32'h0010_0113);
        repeat (6) step();

        // Backpressure from reset: FIFO fills, PC stalls at 8
        reset_n = 1'b0; id_ready = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (4) step();
        chk("stall_imem_a", {26'b0, imem_a}, 32'h2);
        id_ready = 1'b1;
        repeat (4) step();

        // Redirect with a full FIFO
        id_ready = 1'b0;
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 32'h0C;
        step();
        redirect_valid = 1'b0;
        chk("redir_flush", {31'b0, id_valid}, 32'h0);
        step();
        chk("redir_pc", id_pc, 32'h0C);
        chk("redir_instr", id_instr, mem[3]);
        id_ready = 1'b1;
        repeat (3) step();

        // Misaligned redirect faults, a good redirect recovers
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        step();
        chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
        chk("mis_fault_pc", fault_pc, 32'h102);
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        chk("recover_fault", {31'b0, fetch_fault}, 32'h0);
        repeat (3) step();

        // Sequential fetch runs off the end of memory
        redirect_valid = 1'b1; redirect_pc = 32'hF0;
        step();
        redirect_valid = 1'b0;
        repeat (8) step();
        chk("top_fault_pc", fault_pc, 32'h100);

        // Full and faulted, then a one-cycle reset
        id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hF8;
        step();
        redirect_valid = 1'b0;
        repeat (4) step();
        chk("full_fault", {31'b0, fetch_fault}, 32'h1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("rst2_valid", {31'b0, id_valid}, 32'h0);
        chk("rst2_fault", {31'b0, fetch_fault}, 32'h0);
        chk("rst2_imem_a", {26'b0, imem_a}, 32'h0);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
                1:       redirect_pc = 32'hE0 + 32'($urandom_range(0, 7)) * 4;
                2:       redirect_pc = 32'($urandom_range(0, 300));
                default: redirect_pc = $urandom;
            endcase
            reset_n = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the 64-word instruction memory.
- Owns the program counter and drives the memory's word address. Captures the combinational instruction word returned by the memory.
- Buffers {pc, instr} pairs in a small FIFO toward decode, with a valid/ready handshake.
- Accepts redirects (branch/jal/jalr) from execute, and flags misaligned or out-of-range fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 6, instruction-memory word-address width (memory depth 2^IMEM_AW words).
- DEPTH, 2, FIFO entries toward decode (power of two, ≥2).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- imem_a  output  IMEM_AW  word address to the instruction memory, equal to pc[IMEM_AW+1:2], combinational from the pc register.
- imem_rd  input  32  instruction word from the memory, combinational in imem_a.
- redirect_valid  input  1  execute requests a PC change.
- redirect_pc  input  32  new PC target.
- id_valid  output  1  FIFO head holds a valid entry.
- id_ready  input  1  decode accepts the head this cycle.
- id_instr  output  32  head instruction.
- id_pc  output  32  head PC.
- fetch_fault  output  1  fetch stopped on a bad PC.
- fault_pc  output  32  the offending PC.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - pc←RESET_PC, FIFO emptied, state←RUN.
  - id_valid=0, id_instr=0, id_pc=0, fetch_fault=0, fault_pc=0.
  - Reset mid-operation discards all buffered entries and any pending redirect.
- States:
  - RUN: fetching.
  - FAULT: fetch stopped.
- Legal PC: pc[1:0]==0 and pc[31:IMEM_AW+2]==0. Any other PC is a bad PC.
- Push rule in RUN: push {pc, imem_rd} and pc←pc+4 when all of the following hold:
  - redirect_valid=0,
  - the FIFO is not full, or a pop occurs this same cycle,
  - pc is legal.
- Pop: occurs when id_valid && id_ready.
  - Simultaneous push and pop when full is allowed; the count stays DEPTH.
  - When empty, a push makes the entry visible on id_valid the next cycle. Fetch-to-decode latency is 1 cycle.
- Full with no pop: pc holds, imem_a holds, nothing is pushed (stall).
- Redirect has top priority, in any state:
  - FIFO flushed (including the head, even if popped the same cycle).
  - pc←redirect_pc, no push that cycle, id_valid=0 the next cycle.
  - If redirect_pc is legal: state←RUN, fetch_fault←0.
  - If redirect_pc is bad: handled by the bad-PC rule on the following cycle.
- Bad PC in RUN with no redirect:
  - No push; state←FAULT next cycle; fetch_fault←1; fault_pc←pc.
  - Entries already buffered still drain normally.
- FAULT: no pushes, pc frozen. Only a redirect or reset leaves FAULT.
- PC arithmetic: 32-bit modulo. No wrap in the address: overflow past the top of memory makes pc illegal, which faults; imem_a never silently wraps.
- Output registering:
  - id_instr/id_pc are the FIFO head storage registers, stable while id_valid=1 and id_ready=0.
  - When the FIFO is empty, id_instr/id_pc hold their last values; this is don't-care except immediately after reset (0).

Test Plan:
- Reset release, id_ready=1, memory word 0=32'h00000093, word 1=32'h00100113 → imem_a=0 at cycle 0. Cycle 1: id_valid=1, id_pc=0, id_instr=32'h00000093. Cycle 2: id_pc=4, id_instr=32'h00100113. One entry per cycle thereafter.
- Hold id_ready=0 from reset → FIFO fills after 2 pushes; pc stalls at 8; imem_a=2. Release id_ready → entries pc=0,4,8 emerge in order, no loss or duplication.
- Redirect_valid=1, redirect_pc=32'h0C while the FIFO holds 2 entries → next cycle id_valid=0. Following cycle: id_pc=32'h0C with the word-3 instruction.
- Redirect to 32'h0000_0102 (misaligned) → one cycle later fetch_fault=1, fault_pc=32'h102, no further pushes. Redirect to 32'h10 → fetch_fault=0 and fetching resumes at word 4.
- Sequential fetch reaching pc=32'h100 (IMEM_AW=6) → fault with fault_pc=32'h100. Prior entry pc=32'hFC still delivered.
- Assert reset_n=0 for one cycle while the FIFO is full and in FAULT → next cycle: id_valid=0, fetch_fault=0, imem_a=0, pc=RESET_PC.
